mem_access: RTL and testbench



---
 rtl/mem_access.sv | 202 ++++++++++++++++++++
 tb/tb_mem_access.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access.sv
// mem_access: memory-access stage between the EX/MEM and MEM/WB registers.
// Non-memory results pass straight through. Loads and stores become single-beat
// strobe/ack bus cycles with big-endian lane steering and load extension.
// The pipeline is held through stallreq until the bus acknowledges.
//
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   stall[5:0]         pipeline stall vector, bit 4 stops the MEM/WB stage
//   mem_*              EX/MEM register contents (dest, write enable, ALU result,
//                      sub-op, effective address, store data)
//   wb_*               result towards MEM/WB
//   stallreq           stall request to the stall controller
//   bus_*_o            registered bus request (addr, data, sel, we, stb)
//   bus_data_i/ack_i   bus response
//   misalign_o         misaligned-access flag
//
// Optional feature: define MISALIGN_EXC_EN to flag misaligned halfword/word
// accesses instead of issuing them. Without it misalign_o is tied 0.
//
// state | meaning
// IDLE  | pass-through; memory op issues the request at the edge
// WAIT  | strobe high, waiting for bus_ack_i
// HOLD  | access done, present result until stall[4] releases

module mem_access (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic [4:0]  mem_wd,
  input  logic        mem_wreg,
  input  logic [31:0] mem_wdata,
  input  logic [7:0]  mem_aluop,
  input  logic [31:0] mem_mem_addr,
  input  logic [31:0] mem_reg2,
  output logic [4:0]  wb_wd,
  output logic        wb_wreg,
  output logic [31:0] wb_wdata,
  output logic        stallreq,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_data_o,
  output logic [3:0]  bus_sel_o,
  output logic        bus_we_o,
  output logic        bus_stb_o,
  input  logic [31:0] bus_data_i,
  input  logic        bus_ack_i,
  output logic        misalign_o
);

  localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
  localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
  localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
  localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
  localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
  localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
  localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
  localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;

  typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;

  state_t      state, state_d;
  logic        is_load, is_store, is_mem, misaligned;
  logic        start, ack_take;
  logic [3:0]  req_sel;
  logic [31:0] req_data;
  logic [7:0]  op_q;
  logic [1:0]  off_q;
  logic [31:0] load_q, ld_data;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic        unused_stall;

  assign unused_stall = ^{stall[5], stall[3:0]};

  assign is_load  = (mem_aluop == EXE_LB_OP) || (mem_aluop == EXE_LBU_OP) ||
                    (mem_aluop == EXE_LH_OP) || (mem_aluop == EXE_LHU_OP) ||
                    (mem_aluop == EXE_LW_OP);
  assign is_store = (mem_aluop == EXE_SB_OP) || (mem_aluop == EXE_SH_OP) ||
                    (mem_aluop == EXE_SW_OP);
  assign is_mem   = is_load || is_store;

`ifdef MISALIGN_EXC_EN
  assign misaligned = (((mem_aluop == EXE_LH_OP) || (mem_aluop == EXE_LHU_OP) ||
                        (mem_aluop == EXE_SH_OP)) && mem_mem_addr[0]) ||
                      (((mem_aluop == EXE_LW_OP) || (mem_aluop == EXE_SW_OP)) &&
                        (mem_mem_addr[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  // Request lane select and replicated store data (big-endian: byte 0 = [31:24])
  always_comb begin
    req_sel  = 4'b1111;
    req_data = mem_reg2;
    case (mem_aluop)
      EXE_LB_OP, EXE_LBU_OP, EXE_SB_OP: req_sel = 4'b1000 >> mem_mem_addr[1:0];
      EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP: req_sel = mem_mem_addr[1] ? 4'b0011 : 4'b1100;
      default:                          req_sel = 4'b1111;
    endcase
    if (mem_aluop == EXE_SB_OP) req_data = {4{mem_reg2[7:0]}};
    if (mem_aluop == EXE_SH_OP) req_data = {2{mem_reg2[15:0]}};
  end

  // Load steering uses the op/offset latched with the request
  always_comb begin
    case (off_q)
      2'd0:    byte_v = bus_data_i[31:24];
      2'd1:    byte_v = bus_data_i[23:16];
      2'd2:    byte_v = bus_data_i[15:8];
      default: byte_v = bus_data_i[7:0];
    endcase
    half_v = off_q[1] ? bus_data_i[15:0] : bus_data_i[31:16];
    case (op_q)
      EXE_LB_OP:  ld_data = {{24{byte_v[7]}}, byte_v};
      EXE_LBU_OP: ld_data = {24'd0, byte_v};
      EXE_LH_OP:  ld_data = {{16{half_v[15]}}, half_v};
      EXE_LHU_OP: ld_data = {16'd0, half_v};
      default:    ld_data = bus_data_i;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d    = state;
    stallreq   = 1'b0;
    wb_wd      = mem_wd;
    wb_wreg    = mem_wreg;
    wb_wdata   = mem_wdata;
    misalign_o = 1'b0;
    start      = 1'b0;
    ack_take   = 1'b0;
    case (state)
      IDLE: begin
        if (is_mem) begin
          wb_wreg = 1'b0;
          if (misaligned) begin
            misalign_o = 1'b1;
          end else begin
            stallreq = 1'b1;
            start    = 1'b1;
            state_d  = WAIT;
          end
        end
      end
      WAIT: begin
        stallreq = 1'b1;
        wb_wreg  = 1'b0;
        if (bus_stb_o && bus_ack_i) begin
          ack_take = 1'b1;
          state_d  = HOLD;
        end
      end
      HOLD: begin
        if (op_q[3] == 1'b0) wb_wdata = load_q;  // loads have bit 3 clear
        if (!stall[4]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Reset must clear the combinational outputs too, not just the flops
    if (rst) begin
      stallreq   = 1'b0;
      wb_wd      = 5'd0;
      wb_wreg    = 1'b0;
      wb_wdata   = 32'd0;
      misalign_o = 1'b0;
      start      = 1'b0;
      ack_take   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus_addr_o <= 32'd0;
      bus_data_o <= 32'd0;
      bus_sel_o  <= 4'd0;
      bus_we_o   <= 1'b0;
      bus_stb_o  <= 1'b0;
      op_q       <= 8'd0;
      off_q      <= 2'd0;
      load_q     <= 32'd0;
    end else begin
      if (start) begin
        bus_addr_o <= {mem_mem_addr[31:2], 2'b00};
        bus_data_o <= req_data;
        bus_sel_o  <= req_sel;
        bus_we_o   <= is_store;
        bus_stb_o  <= 1'b1;
        op_q       <= mem_aluop;
        off_q      <= mem_mem_addr[1:0];
      end
      if (ack_take) begin
        load_q    <= ld_data;
        bus_stb_o <= 1'b0;
        bus_we_o  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_access.sv
module tb_mem_access;

  localparam logic [7:0] ADD = 8'b0010_0000;
  localparam logic [7:0] LB  = 8'b1110_0000;
  localparam logic [7:0] LH  = 8'b1110_0001;
  localparam logic [7:0] LW  = 8'b1110_0011;
  localparam logic [7:0] LBU = 8'b1110_0100;
  localparam logic [7:0] SB  = 8'b1110_1000;
  localparam logic [7:0] SH  = 8'b1110_1001;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic [4:0]  mem_wd;
  logic        mem_wreg;
  logic [31:0] mem_wdata, mem_mem_addr, mem_reg2;
  logic [7:0]  mem_aluop;
  logic [4:0]  wb_wd;
  logic        wb_wreg, stallreq, bus_we_o, bus_stb_o, bus_ack_i, misalign_o;
  logic [31:0] wb_wdata, bus_addr_o, bus_data_o, bus_data_i;
  logic [3:0]  bus_sel_o;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [31:0] sb_q[$];

  always #5 clk = ~clk;

  mem_access dut (
    .clk(clk), .rst(rst), .stall(stall),
    .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
    .mem_aluop(mem_aluop), .mem_mem_addr(mem_mem_addr), .mem_reg2(mem_reg2),
    .wb_wd(wb_wd), .wb_wreg(wb_wreg), .wb_wdata(wb_wdata), .stallreq(stallreq),
    .bus_addr_o(bus_addr_o), .bus_data_o(bus_data_o), .bus_sel_o(bus_sel_o),
    .bus_we_o(bus_we_o), .bus_stb_o(bus_stb_o),
    .bus_data_i(bus_data_i), .bus_ack_i(bus_ack_i), .misalign_o(misalign_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic at_drive;
    @(posedge clk);
    #1;
  endtask

  task automatic at_samp;
    @(negedge clk);
  endtask

  function automatic logic [31:0] model_load(input logic [7:0] op, input logic [31:0] addr,
                                             input logic [31:0] rdata);
    logic [31:0] b, h;
    b = (rdata >> (8 * (3 - addr[1:0]))) & 32'hFF;
    h = (rdata >> (addr[1] ? 0 : 16)) & 32'hFFFF;
    case (op)
      LB:      return b[7]  ? (b | 32'hFFFFFF00) : b;
      LBU:     return b;
      LH:      return h[15] ? (h | 32'hFFFF0000) : h;
      LW:      return rdata;
      default: return h;
    endcase
  endfunction

  task automatic mem_op(input string tag, input logic [7:0] op, input logic [31:0] addr,
                        input logic [31:0] reg2, input int ack_dly, input logic [31:0] rdata,
                        input logic [31:0] exp_baddr, input logic [3:0] exp_sel,
                        input logic [31:0] exp_bdata, input logic exp_we, input int hold_stop);
    int stall_cycles;
    logic ld;
    logic [31:0] expw;
    stall_cycles = 0;
    ld = !exp_we;
    at_drive;
    mem_aluop = op; mem_mem_addr = addr; mem_reg2 = reg2;
    mem_wd = 5'd9; mem_wreg = ld; mem_wdata = 32'h0BAD0000 | addr;
    bus_ack_i = 1'b0; bus_data_i = 32'h0;
    sb_q.push_back(ld ? model_load(op, addr, rdata) : mem_wdata);
    at_samp;
    if (stallreq) stall_cycles++;
    chk({tag, " req_stb"}, {31'd0, bus_stb_o}, 32'd0);
    chk({tag, " req_wreg"}, {31'd0, wb_wreg}, 32'd0);
    for (int w = 1; w <= ack_dly; w++) begin
      at_drive;
      bus_ack_i  = (w == ack_dly);
      bus_data_i = (w == ack_dly) ? rdata : 32'hA5A5A5A5;
      at_samp;
      if (stallreq) stall_cycles++;
      chk({tag, " wait_stb"}, {31'd0, bus_stb_o}, 32'd1);
      chk({tag, " wait_wreg"}, {31'd0, wb_wreg}, 32'd0);
      if (w == 1) begin
        chk({tag, " addr"}, bus_addr_o, exp_baddr);
        chk({tag, " sel"}, {28'd0, bus_sel_o}, {28'd0, exp_sel});
        chk({tag, " we"}, {31'd0, bus_we_o}, {31'd0, exp_we});
        if (exp_we) chk({tag, " bdata"}, bus_data_o, exp_bdata);
      end
    end
    at_drive;
    bus_ack_i = 1'b0; bus_data_i = 32'h5A5A5A5A;
    stall[4] = (hold_stop > 0);
    chk({tag, " stall_cycles"}, stall_cycles, 1 + ack_dly);
    expw = sb_q.pop_front();
    for (int h = 0; h <= hold_stop; h++) begin
      at_samp;
      chk({tag, " hold_stallreq"}, {31'd0, stallreq}, 32'd0);
      chk({tag, " hold_stb"}, {31'd0, bus_stb_o}, 32'd0);
      chk({tag, " hold_we"}, {31'd0, bus_we_o}, 32'd0);
      chk({tag, " hold_wdata"}, wb_wdata, expw);
      chk({tag, " hold_wreg"}, {31'd0, wb_wreg}, {31'd0, ld});
      chk({tag, " hold_wd"}, {27'd0, wb_wd}, 32'd9);
      if (h < hold_stop) begin
        at_drive;
        stall[4] = (h + 1 < hold_stop);
      end
    end
  endtask

  initial begin
    rst = 1'b1; stall = 6'd0; bus_ack_i = 1'b0; bus_data_i = 32'd0;
    mem_wd = 5'd5; mem_wreg = 1'b1; mem_wdata = 32'h123; mem_aluop = LW;
    mem_mem_addr = 32'h40; mem_reg2 = 32'h0;

    // Reset: everything zero even with live inputs
    at_samp;
    chk("rst wb_wd", {27'd0, wb_wd}, 32'd0);
    chk("rst wb_wreg", {31'd0, wb_wreg}, 32'd0);
    chk("rst wb_wdata", wb_wdata, 32'd0);
    chk("rst stallreq", {31'd0, stallreq}, 32'd0);
    chk("rst stb", {31'd0, bus_stb_o}, 32'd0);
    chk("rst addr", bus_addr_o, 32'd0);
    chk("rst sel", {28'd0, bus_sel_o}, 32'd0);
    chk("rst misalign", {31'd0, misalign_o}, 32'd0);
    mem_aluop = ADD;
    at_drive;
    rst = 1'b0;

    // Non-memory pass-through, same cycle
    at_drive;
    mem_aluop = ADD; mem_wd = 5'd5; mem_wreg = 1'b1; mem_wdata = 32'h00001234;
    #1;
    chk("add wb_wd", {27'd0, wb_wd}, 32'd5);
    chk("add wb_wdata", wb_wdata, 32'h00001234);
    chk("add wb_wreg", {31'd0, wb_wreg}, 32'd1);
    chk("add stallreq", {31'd0, stallreq}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      at_samp;
      chk("add stb", {31'd0, bus_stb_o}, 32'd0);
    end

    mem_op("lb",  LB,  32'h103, 32'h0, 2, 32'h112233F0, 32'h100, 4'b0001, 32'h0, 1'b0, 0);
    mem_op("lbu", LBU, 32'h103, 32'h0, 2, 32'h112233F0, 32'h100, 4'b0001, 32'h0, 1'b0, 0);
    mem_op("sh",  SH,  32'h102, 32'h0000ABCD, 1, 32'h0, 32'h100, 4'b0011, 32'hABCDABCD, 1'b1, 0);
    mem_op("sb",  SB,  32'h201, 32'h12345677, 3, 32'h0, 32'h200, 4'b0100, 32'h77777777, 1'b1, 0);
    mem_op("lh",  LH,  32'h300, 32'h0, 1, 32'h80011234, 32'h300, 4'b1100, 32'h0, 1'b0, 0);
    mem_op("lw",  LW,  32'h400, 32'h0, 1, 32'hDEADBEEF, 32'h400, 4'b1111, 32'h0, 1'b0, 2);

    // Back in IDLE: pass-through again
    at_drive;
    mem_aluop = ADD; mem_wd = 5'd3; mem_wreg = 1'b1; mem_wdata = 32'hCAFE0001;
    #1;
    chk("idle wb_wdata", wb_wdata, 32'hCAFE0001);
    chk("idle stallreq", {31'd0, stallreq}, 32'd0);

    // Reset pulsed mid-WAIT, late ack afterwards is ignored
    at_drive;
    mem_aluop = LW; mem_mem_addr = 32'h500; mem_wd = 5'd7; mem_wdata = 32'h77;
    at_drive;
    at_samp;
    chk("mid stb", {31'd0, bus_stb_o}, 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("rstwait stb", {31'd0, bus_stb_o}, 32'd0);
    chk("rstwait stallreq", {31'd0, stallreq}, 32'd0);
    chk("rstwait wb_wd", {27'd0, wb_wd}, 32'd0);
    chk("rstwait wb_wdata", wb_wdata, 32'd0);
    at_drive;
    mem_aluop = ADD;
    at_drive;
    rst = 1'b0; bus_ack_i = 1'b1;
    at_samp;
    chk("lateack stb", {31'd0, bus_stb_o}, 32'd0);
    chk("lateack stallreq", {31'd0, stallreq}, 32'd0);
    at_samp;
    chk("lateack stb2", {31'd0, bus_stb_o}, 32'd0);
    chk("lateack wdata", wb_wdata, 32'h77);
    at_drive;
    bus_ack_i = 1'b0;

`ifdef MISALIGN_EXC_EN
    at_drive;
    mem_aluop = LW; mem_mem_addr = 32'h101; mem_wreg = 1'b1;
    #1;
    chk("mis flag", {31'd0, misalign_o}, 32'd1);
    chk("mis stallreq", {31'd0, stallreq}, 32'd0);
    chk("mis wreg", {31'd0, wb_wreg}, 32'd0);
    at_samp;
    at_samp;
    chk("mis stb", {31'd0, bus_stb_o}, 32'd0);
    at_drive;
    mem_aluop = ADD;
`else
    mem_op("lw_mis", LW, 32'h101, 32'h0, 1, 32'h01020304, 32'h100, 4'b1111, 32'h0, 1'b0, 0);
    at_drive;
    mem_aluop = ADD;
    #1;
    chk("nomis flag", {31'd0, misalign_o}, 32'd0);
`endif

    at_samp;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
